// File: rtl/wb_iodecode64.sv
// rtl/wb_iodecode64.sv - Wishbone 64-bit I/O address decode and response stage
// Decodes one master request to a peripheral slot, pulses its select, and returns one registered response.
package fta_bus_pkg;
  typedef enum logic [2:0] {
    CLASSIC = 3'd0,
    FIXED   = 3'd1,
    INCR    = 3'd2,
    ERC     = 3'd3,
    EOB     = 3'd7
  } cti_t;

  typedef enum logic [1:0] {
    OKAY    = 2'd0,
    DECERR  = 2'd1,
    PROTERR = 2'd2,
    ERR     = 2'd3
  } err_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    cti_t        cti;
    logic [7:0]  tid;
    logic [31:0] adr;
    logic [7:0]  sel;
    logic [63:0] dat;
  } wb_cmd_request64_t;

  typedef struct packed {
    logic        ack;
    logic        rty;
    err_t        err;
    logic [3:0]  pri;
    logic [7:0]  tid;
    logic [63:0] dat;
  } wb_cmd_response64_t;
endpackage

module wb_iodecode64
  import fta_bus_pkg::*;
#(
  parameter int          NSLV = 4,
  parameter logic [31:0] BASE [NSLV] = '{32'hFEDC0000, 32'hFEDC0100, 32'hFEDC0200, 32'hFEDC0300},
  parameter logic [31:0] MASK [NSLV] = '{default: 32'hFFFFFF00},
  parameter int          TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  wb_cmd_request64_t  req,
  output wb_cmd_response64_t resp,
  output logic [NSLV-1:0]    cs,
  output wb_cmd_request64_t  sreq,
  input  wb_cmd_response64_t sresp [NSLV]
);

  localparam int         IW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state, state_d;
  logic [7:0]         cnt, cnt_d;
  logic [IW-1:0]      idx, idx_d, hit_idx;
  logic               hit;
  logic [NSLV-1:0]    cs_d;
  wb_cmd_request64_t  sreq_d;
  wb_cmd_response64_t resp_d, sel_resp;
  logic               posted;

  // Scan downward so the lowest matching slot is the one left in hit_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((req.adr & MASK[i]) == BASE[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign sel_resp = sresp[idx];
  assign posted   = sreq.we && (sreq.cti != ERC);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sreq_d  = sreq;
    cs_d    = '0;
    resp_d  = '0;
    case (state)
      IDLE: begin
        if (req.cyc && req.stb) begin
          if (hit) begin
            sreq_d       = req;
            idx_d        = hit_idx;
            cnt_d        = '0;
            cs_d[hit_idx] = 1'b1;
            state_d      = WAIT;
          end else begin
            resp_d.ack = 1'b1;
            resp_d.err = DECERR;
            resp_d.pri = 4'd7;
            resp_d.tid = req.tid;
            state_d    = DONE;
          end
        end
      end
      WAIT: begin
        if (posted) begin
          // Posted writes are acknowledged by the bridge while cs is still high.
          resp_d.ack = 1'b1;
          resp_d.err = OKAY;
          resp_d.pri = 4'd7;
          resp_d.tid = sreq.tid;
          state_d    = DONE;
        end else if (sel_resp.ack) begin
          resp_d     = sel_resp;
          resp_d.ack = 1'b1;
          resp_d.tid = sreq.tid;
          state_d    = DONE;
        end else if (cnt == TO8) begin
          resp_d.ack = 1'b1;
          resp_d.err = DECERR;
          resp_d.pri = 4'd7;
          resp_d.tid = sreq.tid;
          state_d    = DONE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      DONE: begin
        if (!(req.cyc && req.stb)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      cs    <= '0;
      sreq  <= '0;
      resp  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      cs    <= cs_d;
      sreq  <= sreq_d;
      resp  <= resp_d;
    end
  end

endmodule

// File: tb/tb_wb_iodecode64.sv
// tb/tb_wb_iodecode64.sv - randomized self-checking bench for wb_iodecode64
// Transaction-level model predicts select, ack cycle and response contents.
module tb_wb_iodecode64;
  import fta_bus_pkg::*;

  localparam int NS = 4;
  localparam int TO = 16;
  localparam logic [31:0] M_BASE [NS] = '{32'hFEDC0000, 32'hFEDC0100, 32'hFEDC0200, 32'hFEDC0300};
  localparam logic [31:0] M_MASK [NS] = '{default: 32'hFFFFFF00};
  localparam logic [31:0] O_BASE [NS] = '{32'hFEDC0000, 32'hFEDC0000, 32'hFEDC0200, 32'hFEDC0300};
  localparam logic [31:0] O_MASK [NS] = '{32'hFFFFFF00, 32'hFFFFF000, 32'hFFFFFF00, 32'hFFFFFF00};

  logic clk = 1'b0;
  logic rst;
  wb_cmd_request64_t  req, sreq, req_ov, sreq_ov;
  wb_cmd_response64_t resp, resp_ov;
  wb_cmd_response64_t sresp [NS];
  wb_cmd_response64_t sresp_ov [NS];
  logic [NS-1:0] cs, cs_ov;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_iodecode64 #(.NSLV(NS), .BASE(M_BASE), .MASK(M_MASK), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .resp(resp), .cs(cs), .sreq(sreq), .sresp(sresp)
  );

  wb_iodecode64 #(.NSLV(NS), .BASE(O_BASE), .MASK(O_MASK), .TIMEOUT(TO)) dut_ov (
    .clk(clk), .rst(rst), .req(req_ov), .resp(resp_ov), .cs(cs_ov), .sreq(sreq_ov), .sresp(sresp_ov)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_slot(input logic [31:0] adr, input logic [31:0] b [NS], input logic [31:0] m [NS]);
    for (int i = 0; i < NS; i++)
      if ((adr & m[i]) == b[i]) return i;
    return -1;
  endfunction

  function automatic wb_cmd_response64_t rand_resp(input logic ack);
    wb_cmd_response64_t x;
    x.ack = ack;
    x.rty = 1'($urandom);
    x.err = err_t'($urandom_range(0, 3));
    x.pri = 4'($urandom);
    x.tid = 8'($urandom);
    x.dat = {$urandom, $urandom};
    return x;
  endfunction

  task automatic clear_slaves();
    for (int s = 0; s < NS; s++) begin
      sresp[s]    = '0;
      sresp_ov[s] = '0;
    end
  endtask

  // ca: cycle the selected slave acks (0 = never); extra: cycles stb is held past the ack.
  task automatic run_txn(input string tag, input logic [31:0] adr, input logic we, input cti_t cti,
                         input logic [63:0] dat, input int ca, input int extra, input wb_cmd_response64_t sr);
    wb_cmd_request64_t  r, sreq1;
    wb_cmd_response64_t er, rat, sra;
    int slot, eack, drop, first_ack, n_ack, cs_bad;
    logic [NS-1:0] cs1, exp_cs;
    slot = exp_slot(adr, M_BASE, M_MASK);
    r = '0;
    r.cyc = 1'b1; r.stb = 1'b1; r.we = we; r.cti = cti;
    r.tid = 8'($urandom); r.adr = adr; r.sel = 8'($urandom); r.dat = dat;
    sra = sr;
    sra.ack = 1'b1;
    er = '0;
    er.ack = 1'b1; er.pri = 4'd7; er.tid = r.tid;
    if (slot < 0) begin
      eack = 1; er.err = DECERR;
    end else if (we && cti != ERC) begin
      eack = 2; er.err = OKAY;
    end else if (ca != 0 && ca <= TO + 1) begin
      eack = ca + 1; er = sra; er.tid = r.tid;
    end else begin
      eack = TO + 2; er.err = DECERR;
    end
    exp_cs = '0;
    if (slot >= 0) exp_cs[slot] = 1'b1;
    drop = eack + 1 + extra;
    first_ack = -1; n_ack = 0; cs_bad = 0; cs1 = '0; sreq1 = '0; rat = '0;
    @(posedge clk); #1;
    req = r;
    for (int k = 1; k <= drop + 3; k++) begin
      @(posedge clk); #1;
      if (k == drop) req = '0;
      for (int s = 0; s < NS; s++) begin
        if (s == slot) sresp[s] = (k == ca) ? sra : rand_resp(1'b0);
        else           sresp[s] = rand_resp($urandom_range(0, 3) == 0);
      end
      if (k == 1) begin
        cs1 = cs; sreq1 = sreq;
      end else if (cs != '0) begin
        cs_bad++;
      end
      if (resp.ack) begin
        n_ack++;
        if (first_ack < 0) begin
          first_ack = k; rat = resp;
        end
      end
    end
    clear_slaves();
    chk({tag, ".cs"}, 128'(cs1), 128'(exp_cs));
    chk({tag, ".cs_extra"}, 128'(cs_bad), 128'(0));
    if (slot >= 0) chk({tag, ".sreq"}, 128'(sreq1), 128'(r));
    chk({tag, ".ack_cycle"}, 128'(first_ack), 128'(eack));
    chk({tag, ".ack_count"}, 128'(n_ack), 128'(1));
    chk({tag, ".resp"}, 128'(rat), 128'(er));
  endtask

  initial begin
    wb_cmd_response64_t sr;
    cti_t ctis [4];
    logic [31:0] adr;
    int pick;
    ctis = '{CLASSIC, INCR, ERC, EOB};
    rst = 1'b1;
    req = '0;
    req_ov = '0;
    clear_slaves();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.cs", 128'(cs), 128'(0));
    chk("rst.resp", 128'(resp), 128'(0));
    chk("rst.sreq", 128'(sreq), 128'(0));
    chk("rst.cs_ov", 128'(cs_ov), 128'(0));
    rst = 1'b0;

    sr = rand_resp(1'b0); sr.dat = 64'h55; sr.err = OKAY; sr.rty = 1'b0;
    run_txn("rd0", 32'hFEDC0008, 1'b0, CLASSIC, 64'h0, 2, 1, sr);
    run_txn("pw1", 32'hFEDC0100, 1'b1, CLASSIC, 64'hA5, 2, 1, rand_resp(1'b0));
    run_txn("miss", 32'h00001000, 1'b0, CLASSIC, 64'h0, 0, 3, rand_resp(1'b0));
    run_txn("to3", 32'hFEDC0300, 1'b0, CLASSIC, 64'h0, 20, 3, rand_resp(1'b0));
    run_txn("ack_at_to", 32'hFEDC0204, 1'b0, INCR, 64'h0, TO + 1, 1, rand_resp(1'b0));
    run_txn("ack_after_to", 32'hFEDC0104, 1'b0, CLASSIC, 64'h0, TO + 2, 2, rand_resp(1'b0));
    run_txn("erc_wr", 32'hFEDC02F0, 1'b1, ERC, 64'h1234, 3, 0, rand_resp(1'b0));

    // Reset while waiting on a slave, then a late slave ack.
    @(posedge clk); #1;
    req = '0; req.cyc = 1'b1; req.stb = 1'b1; req.adr = 32'hFEDC0210; req.tid = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    sresp[2] = rand_resp(1'b1);
    chk("rstw.cs", 128'(cs), 128'(0));
    chk("rstw.resp", 128'(resp), 128'(0));
    @(posedge clk); #1;
    sresp[2] = '0;
    chk("rstw.late_ack", 128'(resp.ack), 128'(0));
    @(posedge clk); #1;
    chk("rstw.late_ack2", 128'(resp.ack), 128'(0));
    run_txn("rd_after_rst", 32'hFEDC0210, 1'b0, CLASSIC, 64'h0, 2, 0, rand_resp(1'b0));

    // Overlapping decode: slot 1 also covers slot 0's range.
    @(posedge clk); #1;
    req_ov = '0; req_ov.cyc = 1'b1; req_ov.stb = 1'b1; req_ov.adr = 32'hFEDC0010; req_ov.tid = 8'h5A;
    @(posedge clk); #1;
    chk("ov.cs", 128'(cs_ov), 128'(4'b0001));
    @(posedge clk); #1;
    chk("ov.cs_clear", 128'(cs_ov), 128'(0));
    sresp_ov[1] = rand_resp(1'b1);
    @(posedge clk); #1;
    sresp_ov[1] = '0;
    sresp_ov[0] = '0; sresp_ov[0].ack = 1'b1; sresp_ov[0].dat = 64'h77;
    chk("ov.other_ack", 128'(resp_ov.ack), 128'(0));
    @(posedge clk); #1;
    sresp_ov[0] = '0;
    chk("ov.ack", 128'(resp_ov.ack), 128'(1));
    chk("ov.dat", 128'(resp_ov.dat), 128'(64'h77));
    chk("ov.tid", 128'(resp_ov.tid), 128'(8'h5A));
    @(posedge clk); #1;
    req_ov = '0;

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      if (pick < NS) adr = M_BASE[pick] | 32'($urandom_range(0, 255));
      else           adr = $urandom;
      run_txn($sformatf("rnd%0d", n), adr, 1'($urandom), ctis[$urandom_range(0, 3)],
              {$urandom, $urandom}, $urandom_range(0, 20), $urandom_range(0, 3), rand_resp(1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_iodecode64.md
Name: wb_iodecode64

Overview:
- Upstream address-decode and response stage for the 64-bit Wishbone I/O peripherals (LED port, switches, timers).
- Takes one master request, asserts a one-cycle chip select to the matching peripheral, and forwards a registered copy of the request.
- Returns a single registered response to the master: the peripheral's response, a bridge-generated posted-write ack, or a decode/timeout error.

Parameters:
- NSLV, 4, number of peripheral slots.
- BASE, {32'hFEDC0000, 32'hFEDC0100, 32'hFEDC0200, 32'hFEDC0300}, per-slot base address.
- MASK, {4{32'hFFFFFF00}}, per-slot address compare mask.
- TIMEOUT, 255, WAIT cycles before an error response (8-bit counter).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  wb_cmd_request64_t  master request (cyc, stb, we, cti, tid, adr, sel, dat)
- resp  out  wb_cmd_response64_t  response to master
- cs  out  NSLV  one-hot peripheral select, one-cycle pulse
- sreq  out  wb_cmd_request64_t  registered request broadcast to all peripherals
- sresp  in  NSLV x wb_cmd_response64_t  peripheral responses

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, cs=0, sreq=0, resp=0 (ack, rty, dat all 0; err=OKAY), counter=0, slot index=0.
- Reset asserted mid-transaction aborts it with no ack. A slave ack arriving after reset is ignored.
- States: IDLE, WAIT, DONE.
- Hit rule: (req.adr & MASK[i]) == BASE[i]. If several slots hit, the lowest index wins.
- IDLE, on req.cyc & req.stb with a hit on slot i:
  - capture req into sreq, record i, load counter=0.
  - next cycle: cs[i]=1 for exactly one cycle; go WAIT.
- IDLE, on req.cyc & req.stb with no hit:
  - next cycle: resp.ack=1, err=fta_bus_pkg::DECERR, dat=0, tid=req.tid; go DONE.
  - cs stays 0.
- WAIT, posted write (sreq.we & sreq.cti != ERC):
  - on the cycle cs is high, the bridge registers resp.ack=1, err=OKAY, tid=sreq.tid.
  - go DONE. sresp is ignored for this transaction.
- WAIT, read or ERC write:
  - counter increments each cycle.
  - on sresp[i].ack: next cycle resp = sresp[i] (dat, err, rty, pri), with tid forced to sreq.tid and ack=1; go DONE.
- WAIT timeout: when counter==TIMEOUT with no ack, next cycle resp.ack=1, err=DECERR, dat=0; go DONE.
- Ack and timeout in the same cycle: the ack wins.
- Only sresp[i] of the selected slot is observed. Other slots' acks are ignored in all states.
- DONE: resp.ack returns to 0 (ack is always a one-cycle pulse). Stay until !(req.cyc & req.stb), then go IDLE.
  - A held stb therefore never produces a second transaction.
- resp.rty is always 0 except when passed through from a slave.
- resp.pri comes from the slave on forwarded responses, and is 4'd7 on bridge-generated responses.
- Latency for a read to a slave that acks one cycle after cs (stb seen at cycle 0):
  - cs high at cycle 1; slave ack at cycle 2; master resp.ack at cycle 3.
- Latency for a posted write: cs at cycle 1, resp.ack at cycle 2.
- Counter width is 8 bits. TIMEOUT must be ≤255, and the counter never wraps within one transaction.

Test Plan:
- Read at adr 32'hFEDC0008, slot 0 acks with dat=64'h55 one cycle after cs -> cs=4'b0001 pulse at cycle 1; resp.ack at cycle 3 with dat=64'h55, tid echoed, err=OKAY.
- Posted write (cti=CLASSIC, dat=8'hA5) to 32'hFEDC0100 -> cs=4'b0010 at cycle 1; sreq.dat=8'hA5; resp.ack=1, err=OKAY at cycle 2; slave ack, if any, ignored.
- Access to 32'h00001000 (no hit) -> cs stays 0; resp.ack at cycle 1 with err=DECERR, dat=0; no further ack while stb is held.
- Read to slot 3 that never acks, TIMEOUT=16 -> resp.ack with err=DECERR at cycle 18. A late sresp[3].ack at cycle 20 produces no resp.ack.
- Overlapping masks (slot 1 mask 32'hFFFFF000, base 32'hFEDC0000) on adr 32'hFEDC0010 -> only cs[0] pulses.
- rst asserted in WAIT -> the next cycle shows cs=0, resp.ack=0, state IDLE. A new read then completes normally with 3-cycle latency.
